// File: rtl/dw_fp_sqrt_inst_if.sv
// Request/response bundle of the sequential floating-point square-root unit.
interface dw_fp_sqrt_inst_if #(
  parameter int inst_sig_width = 23,
  parameter int inst_exp_width = 8
);
  localparam int W = inst_sig_width + inst_exp_width + 1;

  logic         inst_start;
  logic [W-1:0] inst_a;
  logic [2:0]   inst_rnd;
  logic         inst_busy;
  logic         inst_done;
  logic [W-1:0] z_inst;
  logic [7:0]   status_inst;

  modport master (
    output inst_start, inst_a, inst_rnd,
    input  inst_busy, inst_done, z_inst, status_inst
  );

  modport slave (
    input  inst_start, inst_a, inst_rnd,
    output inst_busy, inst_done, z_inst, status_inst
  );
endinterface

// File: rtl/dw_fp_sqrt_inst.sv
// IEEE-754 square root: unpack, one root bit per cycle by restoring recurrence
// (significand plus guard), then round and pack; fixed 27-cycle latency.
module dw_fp_sqrt_inst #(
  parameter int inst_sig_width       = 23,
  parameter int inst_exp_width       = 8,
  parameter int inst_ieee_compliance = 0
) (
  input logic              clk,
  input logic              rst,
  dw_fp_sqrt_inst_if.slave bus
);
  localparam int SW   = inst_sig_width;
  localparam int EW   = inst_exp_width;
  localparam int W    = SW + EW + 1;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam int NIT  = SW + 2;
  localparam int XW   = 2 * NIT;
  localparam int RW   = NIT + 3;
  localparam int CW   = $clog2(NIT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UNPK = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_PACK = 2'd3;

  logic [1:0]    state_q;
  logic [W-1:0]  a_q;
  logic [2:0]    rnd_q;
  logic [CW-1:0] cnt_q;
  logic [XW-1:0] x_q;
  logic [RW-1:0] rem_q;
  logic [NIT-1:0] root_q;
  logic [EW-1:0] rexp_q;
  logic          spec_q;
  logic [W-1:0]  spec_z_q;
  logic [7:0]    spec_st_q;
  logic [W-1:0]  z_q;
  logic [7:0]    st_q;
  logic          done_q;

  logic          sgn, ex_max, ex_zero, fr_zero;
  logic [EW-1:0] ex;
  logic [SW-1:0] fr;
  logic          spec_d;
  logic [W-1:0]  spec_z_d;
  logic [7:0]    spec_st_d;
  logic [SW:0]   m_d;
  logic [XW-1:0] x_d;
  logic [EW-1:0] rexp_d;
  int            msb, e_int;

  always_comb begin
    sgn     = a_q[W-1];
    ex      = a_q[W-2:SW];
    fr      = a_q[SW-1:0];
    ex_max  = &ex;
    ex_zero = ~|ex;
    fr_zero = ~|fr;

    spec_d    = 1'b1;
    spec_z_d  = '0;
    spec_st_d = '0;
    if (ex_max) begin
      if (!fr_zero || sgn) begin
        spec_z_d  = {1'b0, {EW{1'b1}}, 1'b1, {(SW-1){1'b0}}};
        spec_st_d = 8'h04;
      end else begin
        spec_z_d  = {1'b0, {EW{1'b1}}, {SW{1'b0}}};
        spec_st_d = 8'h02;
      end
    end else if (ex_zero && (fr_zero || inst_ieee_compliance == 0)) begin
      spec_z_d  = {sgn, {(W-1){1'b0}}};
      spec_st_d = 8'h01;
    end else if (sgn) begin
      spec_z_d  = {1'b0, {EW{1'b1}}, 1'b1, {(SW-1){1'b0}}};
      spec_st_d = 8'h04;
    end else begin
      spec_d = 1'b0;
    end

    // Denormals are renormalised so the hidden bit sits at position SW.
    msb = 0;
    for (int unsigned i = 0; i < SW; i++)
      if (fr[i]) msb = int'(i);
    if (ex_zero) begin
      m_d   = {1'b0, fr} << (SW - msb);
      e_int = 1 - BIAS - (SW - msb);
    end else begin
      m_d   = {1'b1, fr};
      e_int = int'(ex) - BIAS;
    end

    // Odd exponent folds one factor of 2 into the radicand, keeping it in [1,4).
    x_d    = {{(XW-SW-1){1'b0}}, m_d} << (e_int[0] ? SW + 3 : SW + 2);
    rexp_d = EW'(((e_int - (e_int & 1)) >>> 1) + BIAS);
  end

  logic [RW-1:0]  rem_sh, trial, rem_d;
  logic [NIT-1:0] root_d;
  logic           ge;

  always_comb begin
    rem_sh = {rem_q[RW-3:0], x_q[XW-1:XW-2]};
    trial  = RW'({root_q, 2'b01});
    ge     = rem_sh >= trial;
    rem_d  = ge ? rem_sh - trial : rem_sh;
    root_d = {root_q[NIT-2:0], ge};
  end

  logic          guard, sticky, inc;
  logic [SW:0]   frac_r;
  logic [W-1:0]  z_d;
  logic [7:0]    st_d;

  always_comb begin
    guard  = root_q[0];
    sticky = |rem_q;
    case (rnd_q)
      3'd1, 3'd3: inc = 1'b0;
      3'd2, 3'd5: inc = guard | sticky;
      default:    inc = guard;
    endcase
    frac_r = {1'b0, root_q[SW:1]} + (SW+1)'(inc);
    z_d    = {1'b0, rexp_q + EW'(frac_r[SW]), frac_r[SW-1:0]};
    st_d   = {2'b00, guard | sticky, 5'b00000};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      rnd_q     <= '0;
      cnt_q     <= '0;
      x_q       <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      rexp_q    <= '0;
      spec_q    <= 1'b0;
      spec_z_q  <= '0;
      spec_st_q <= '0;
      z_q       <= '0;
      st_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.inst_start) begin
          a_q     <= bus.inst_a;
          rnd_q   <= bus.inst_rnd;
          state_q <= S_UNPK;
        end
        S_UNPK: begin
          x_q       <= x_d;
          rem_q     <= '0;
          root_q    <= '0;
          rexp_q    <= rexp_d;
          spec_q    <= spec_d;
          spec_z_q  <= spec_z_d;
          spec_st_q <= spec_st_d;
          cnt_q     <= '0;
          state_q   <= S_ITER;
        end
        S_ITER: begin
          x_q    <= x_q << 2;
          rem_q  <= rem_d;
          root_q <= root_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(NIT - 1)) state_q <= S_PACK;
        end
        default: begin
          z_q     <= spec_q ? spec_z_q : z_d;
          st_q    <= spec_q ? spec_st_q : st_d;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.inst_busy   = (state_q != S_IDLE);
  assign bus.inst_done   = done_q;
  assign bus.z_inst      = z_q;
  assign bus.status_inst = st_q;
endmodule

// File: tb/tb_dw_fp_sqrt_inst.sv
// Directed checks of dw_fp_sqrt_inst (binary32, denormals flushed) plus an
// integer sweep against a real-valued sqrt rounded to nearest-even.
module tb_dw_fp_sqrt_inst;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dw_fp_sqrt_inst_if #(.inst_sig_width(23), .inst_exp_width(8)) bus ();

  dw_fp_sqrt_inst #(
    .inst_sig_width(23),
    .inst_exp_width(8),
    .inst_ieee_compliance(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic launch(input logic [31:0] a, input logic [2:0] rnd);
    bus.inst_a     = a;
    bus.inst_rnd   = rnd;
    bus.inst_start = 1'b1;
    @(posedge clk);
    #1;
    bus.inst_start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.inst_done && lat < 60);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [2:0] rnd,
                     input logic [31:0] ez, input logic [7:0] est);
    int lat;
    launch(a, rnd);
    wait_done(lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'd27);
    check_eq({tag, "_z"}, bus.z_inst, ez);
    check_eq({tag, "_st"}, {24'd0, bus.status_inst}, {24'd0, est});
  endtask

  task automatic no_done_for(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (bus.inst_done) seen = 1'b1;
    end
    check_eq(tag, {31'd0, seen}, 32'd0);
  endtask

  function automatic logic [31:0] int2f(input int n);
    int p;
    logic [31:0] u;
    logic [7:0]  e8;
    if (n == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 31; i++) if (n[i]) p = i;
    u  = 32'(n) << (23 - p);
    e8 = 8'(p + 127);
    return {1'b0, e8, u[22:0]};
  endfunction

  function automatic logic [31:0] ref_sqrt(input int n);
    real r, m, f;
    int k, mi;
    logic [23:0] mv;
    logic [7:0]  e8;
    if (n == 0) return 32'd0;
    r = $sqrt(real'(n));
    m = r;
    k = 0;
    while (m >= 2.0) begin
      m = m / 2.0;
      k++;
    end
    m  = m * 8388608.0;
    mi = $rtoi(m);
    f  = m - real'(mi);
    if (f > 0.5 || (f == 0.5 && mi[0])) mi++;
    if (mi == 16777216) begin
      mi = 8388608;
      k++;
    end
    mv = 24'(mi);
    e8 = 8'(k + 127);
    return {1'b0, e8, mv[22:0]};
  endfunction

  initial begin
    int lat;
    int s;
    logic [7:0] est;
    bus.inst_start = 1'b0;
    bus.inst_a     = '0;
    bus.inst_rnd   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_z", bus.z_inst, 32'h0);
    check_eq("rst_st", {24'd0, bus.status_inst}, 32'h0);
    check_eq("rst_busy", {31'd0, bus.inst_busy}, 32'd0);
    check_eq("rst_done", {31'd0, bus.inst_done}, 32'd0);

    run("sqrt4", 32'h40800000, 3'd0, 32'h40000000, 8'h00);
    run("sqrt9", 32'h41100000, 3'd0, 32'h40400000, 8'h00);
    run("sqrt025", 32'h3E800000, 3'd0, 32'h3F000000, 8'h00);

    run("sqrt2_rne", 32'h40000000, 3'd0, 32'h3FB504F3, 8'h20);
    run("sqrt2_rz", 32'h40000000, 3'd1, 32'h3FB504F3, 8'h20);
    run("sqrt2_rpi", 32'h40000000, 3'd2, 32'h3FB504F4, 8'h20);
    run("sqrt2_rmi", 32'h40000000, 3'd3, 32'h3FB504F3, 8'h20);
    run("sqrt2_away", 32'h40000000, 3'd5, 32'h3FB504F4, 8'h20);
    run("sqrt2_r7", 32'h40000000, 3'd7, 32'h3FB504F3, 8'h20);

    run("neg1", 32'hBF800000, 3'd0, 32'h7FC00000, 8'h04);
    run("ninf", 32'hFF800000, 3'd0, 32'h7FC00000, 8'h04);
    run("pinf", 32'h7F800000, 3'd0, 32'h7F800000, 8'h02);
    run("pzero", 32'h00000000, 3'd0, 32'h00000000, 8'h01);
    run("nzero", 32'h80000000, 3'd0, 32'h80000000, 8'h01);
    run("qnan", 32'h7FC00001, 3'd0, 32'h7FC00000, 8'h04);
    run("denorm", 32'h00000001, 3'd2, 32'h00000000, 8'h01);

    // Start while busy: second request must be dropped.
    launch(32'h40800000, 3'd0);
    check_eq("busy_rise", {31'd0, bus.inst_busy}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    bus.inst_a     = 32'h41100000;
    bus.inst_start = 1'b1;
    @(posedge clk);
    #1;
    bus.inst_start = 1'b0;
    wait_done(lat);
    check_eq("ign_lat", 32'(lat), 32'd22);
    check_eq("ign_z", bus.z_inst, 32'h40000000);
    check_eq("ign_busy_fall", {31'd0, bus.inst_busy}, 32'd0);
    no_done_for("ign_no_2nd_done", 35);

    // Back-to-back: new start asserted in the done cycle.
    launch(32'h40000000, 3'd2);
    wait_done(lat);
    check_eq("b2b_lat0", 32'(lat), 32'd27);
    check_eq("b2b_z0", bus.z_inst, 32'h3FB504F4);
    launch(32'h41100000, 3'd0);
    check_eq("b2b_hold", bus.z_inst, 32'h3FB504F4);
    wait_done(lat);
    check_eq("b2b_lat1", 32'(lat), 32'd27);
    check_eq("b2b_z1", bus.z_inst, 32'h40400000);

    // Reset mid-operation aborts without a done pulse.
    launch(32'h40800000, 3'd0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("mid_rst_z", bus.z_inst, 32'h0);
    check_eq("mid_rst_st", {24'd0, bus.status_inst}, 32'h0);
    check_eq("mid_rst_busy", {31'd0, bus.inst_busy}, 32'd0);
    check_eq("mid_rst_done", {31'd0, bus.inst_done}, 32'd0);
    no_done_for("mid_rst_no_done", 35);
    run("post_rst", 32'h41100000, 3'd0, 32'h40400000, 8'h00);

    for (int n = 0; n <= 65535; n += 61) begin
      s   = $rtoi($sqrt(real'(n)));
      est = (n == 0) ? 8'h01 : ((s * s == n) ? 8'h00 : 8'h20);
      run($sformatf("sweep%0d", n), int2f(n), 3'd0, ref_sqrt(n), est);
    end
    run("sweep65535", int2f(65535), 3'd0, ref_sqrt(65535), 8'h20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
